uart_rx: RTL and testbench

- 8N1 UART receiver. Deserialises the board's i_UART_RX pin into bytes for top-level logic, such as the LED, 7-segment and loopback paths in GoBoard.
- Sits directly upstream of the top level. It is driven straight from the i_UART_RX pad.
- Emits one byte per valid frame, with a single-cycle data-valid strobe and a framing-error flag.

---
 rtl/uart_rx.sv | 86 ++++++++
 tb/tb_uart_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with two-flop synchroniser, mid-bit sampling,
// one-cycle data-valid and framing-error strobes.
module uart_rx #(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_RX_Serial,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   output logic       o_RX_Frame_Err,
   output logic       o_RX_Busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;
   state_t state;
   logic sync_a, rx_s;
   logic [CW-1:0] cnt;
   logic [2:0] idx;
   logic [7:0] shift;
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state          <= IDLE;
         cnt            <= '0;
         idx            <= '0;
         shift          <= '0;
         sync_a         <= 1'b1;
         rx_s           <= 1'b1;
         o_RX_DV        <= 1'b0;
         o_RX_Byte      <= '0;
         o_RX_Frame_Err <= 1'b0;
         o_RX_Busy      <= 1'b0;
      end else begin
         {rx_s, sync_a} <= {sync_a, i_RX_Serial};
         o_RX_DV        <= 1'b0;
         o_RX_Frame_Err <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               idx <= '0;
               if (!rx_s) begin
                  state     <= START;
                  o_RX_Busy <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF) begin
                  cnt       <= '0;
                  idx       <= '0;
                  state     <= rx_s ? IDLE : DATA;
                  o_RX_Busy <= !rx_s;
               end else cnt <= cnt + 1'b1;
            end
            DATA: begin
               if (cnt == LAST) begin
                  cnt        <= '0;
                  shift[idx] <= rx_s;
                  if (idx == 3'd7) state <= STOP;
                  else idx <= idx + 1'b1;
               end else cnt <= cnt + 1'b1;
            end
            STOP: begin
               if (cnt == LAST) begin
                  cnt   <= '0;
                  state <= CLEANUP;
                  // sampled mid-stop-bit so a back-to-back start bit is not missed
                  if (rx_s) begin
                     o_RX_Byte <= shift;
                     o_RX_DV   <= 1'b1;
                  end else o_RX_Frame_Err <= 1'b1;
               end else cnt <= cnt + 1'b1;
            end
            CLEANUP: begin
               state     <= IDLE;
               o_RX_Busy <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               o_RX_Busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level model of expected strobes checked every cycle on a
// 217-clock instance, plus a directed latency test on an 8-clock instance.
module tb_uart_rx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx_a = 1'b1, rx_b = 1'b1;
   logic dv_a, fe_a, busy_a, dv_b, fe_b, busy_b;
   logic [7:0] byte_a, byte_b;
   int cyc = 0, n_cmp = 0, n_bad = 0;
   int dv_a_cnt = 0, fe_a_cnt = 0, dv_b_cnt = 0, fe_b_cnt = 0, dv_b_cyc = 0, b_start = 0;
   bit run = 1'b0;
   logic [7:0] held = 8'h00;
   typedef struct {logic fe; logic [7:0] b; int due;} ev_t;
   ev_t q[$];

   uart_rx #(.CLKS_PER_BIT(217)) u_a (
      .i_Clk(clk), .i_Reset(rst), .i_RX_Serial(rx_a), .o_RX_DV(dv_a),
      .o_RX_Byte(byte_a), .o_RX_Frame_Err(fe_a), .o_RX_Busy(busy_a));
   uart_rx #(.CLKS_PER_BIT(8)) u_b (
      .i_Clk(clk), .i_Reset(rst), .i_RX_Serial(rx_b), .o_RX_DV(dv_b),
      .o_RX_Byte(byte_b), .o_RX_Frame_Err(fe_b), .o_RX_Busy(busy_b));

   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic ok, input longint act, input longint exp);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) if (run) begin
      chk("excl_a", !(dv_a && fe_a), {dv_a, fe_a}, 0);
      chk("excl_b", !(dv_b && fe_b), {dv_b, fe_b}, 0);
      if (dv_b) begin
         dv_b_cnt++;
         dv_b_cyc = cyc;
      end
      if (fe_b) fe_b_cnt++;
      if (dv_a) dv_a_cnt++;
      if (fe_a) fe_a_cnt++;
      if (dv_a || fe_a) begin
         chk("strobe_expected", q.size() != 0, q.size(), 1);
         if (q.size() != 0) begin
            automatic ev_t e = q.pop_front();
            chk("strobe_kind", fe_a == e.fe, fe_a, e.fe);
            chk("strobe_time", (cyc - e.due) <= 2 && (e.due - cyc) <= 2, cyc, e.due);
            if (!e.fe) held = e.b;
         end
      end
      chk("byte_held", byte_a == held, byte_a, held);
   end

   task automatic drive(input bit sel, input logic v, input int n);
      if (sel) rx_b = v;
      else rx_a = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input bit sel, input logic [7:0] d, input logic stop);
      int n = sel ? 8 : 217;
      if (!sel) q.push_back('{fe: !stop, b: d, due: cyc + 2 + (n - 1) / 2 + 1 + 9 * n + 1});
      else b_start = cyc;
      drive(sel, 1'b0, n);
      for (int i = 0; i < 8; i++) drive(sel, d[i], n);
      drive(sel, stop, n);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_dv"}, dv_a == 1'b0, dv_a, 0);
      chk({nm, "_byte"}, byte_a == 8'h00, byte_a, 0);
      chk({nm, "_fe"}, fe_a == 1'b0, fe_a, 0);
      chk({nm, "_busy"}, busy_a == 1'b0, busy_a, 0);
   endtask

   initial begin
      int d0, f0;
      logic [7:0] v;
      idle(3);
      rst = 1'b0;
      run = 1'b1;
      chk_reset("reset");
      idle(20);
      // single byte
      d0 = dv_a_cnt;
      send(0, 8'hA5, 1'b1);
      idle(651);
      chk("t1_dv_count", dv_a_cnt - d0 == 1, dv_a_cnt - d0, 1);
      chk("t1_byte", byte_a == 8'hA5, byte_a, 8'hA5);
      chk("t1_fe_count", fe_a_cnt == 0, fe_a_cnt, 0);
      chk("t1_busy", busy_a == 1'b0, busy_a, 0);
      // back-to-back
      d0 = dv_a_cnt;
      send(0, 8'h00, 1'b1);
      send(0, 8'hFF, 1'b1);
      send(0, 8'h3C, 1'b1);
      idle(651);
      chk("t2_dv_count", dv_a_cnt - d0 == 3, dv_a_cnt - d0, 3);
      chk("t2_byte", byte_a == 8'h3C, byte_a, 8'h3C);
      chk("t2_pending", q.size() == 0, q.size(), 0);
      // framing error
      d0 = dv_a_cnt;
      f0 = fe_a_cnt;
      send(0, 8'h55, 1'b0);
      rx_a = 1'b1;
      idle(651);
      chk("t3_fe_count", fe_a_cnt - f0 == 1, fe_a_cnt - f0, 1);
      chk("t3_dv_count", dv_a_cnt == d0, dv_a_cnt - d0, 0);
      chk("t3_byte", byte_a == 8'h3C, byte_a, 8'h3C);
      chk("t3_busy", busy_a == 1'b0, busy_a, 0);
      // glitch rejection
      d0 = dv_a_cnt;
      f0 = fe_a_cnt;
      drive(0, 1'b0, 50);
      rx_a = 1'b1;
      idle(651);
      chk("t4_glitch_dv", dv_a_cnt == d0, dv_a_cnt - d0, 0);
      chk("t4_glitch_fe", fe_a_cnt == f0, fe_a_cnt - f0, 0);
      chk("t4_busy", busy_a == 1'b0, busy_a, 0);
      send(0, 8'h81, 1'b1);
      idle(651);
      chk("t4_byte", byte_a == 8'h81, byte_a, 8'h81);
      chk("t4_dv_count", dv_a_cnt - d0 == 1, dv_a_cnt - d0, 1);
      // reset during bit 4
      d0 = dv_a_cnt;
      f0 = fe_a_cnt;
      v = 8'hC3;
      drive(0, 1'b0, 217);
      for (int i = 0; i < 4; i++) drive(0, v[i], 217);
      drive(0, v[4], 100);
      chk("t5_busy_mid", busy_a == 1'b1, busy_a, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rx_a = 1'b1;
      held = 8'h00;
      chk_reset("t5_after_reset");
      idle(651);
      chk("t5_no_dv", dv_a_cnt == d0, dv_a_cnt - d0, 0);
      chk("t5_no_fe", fe_a_cnt == f0, fe_a_cnt - f0, 0);
      send(0, 8'h12, 1'b1);
      idle(651);
      chk("t5_byte", byte_a == 8'h12, byte_a, 8'h12);
      chk("t5_dv_count", dv_a_cnt - d0 == 1, dv_a_cnt - d0, 1);
      chk("t5_pending", q.size() == 0, q.size(), 0);
      // small parameter: latency 2+4+72+1 = 79
      send(1, 8'h96, 1'b1);
      idle(40);
      chk("t6_dv_count", dv_b_cnt == 1, dv_b_cnt, 1);
      chk("t6_byte", byte_b == 8'h96, byte_b, 8'h96);
      chk("t6_latency", (dv_b_cyc - b_start) >= 77 && (dv_b_cyc - b_start) <= 81, dv_b_cyc - b_start, 79);
      chk("t6_fe_count", fe_b_cnt == 0, fe_b_cnt, 0);
      chk("t6_busy", busy_b == 1'b0, busy_b, 0);
      run = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
